// File: rtl/fabricport_pkg.sv
// fabricport_pkg: shared scheduler state type and packet-layout helpers
package fabricport_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} sched_state_t;

    function automatic int flit_width(input int width_pkt);
        return width_pkt / 4;
    endfunction

    function automatic int valid_pos(input int width_pkt);
        return width_pkt - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting after the last accepted winner
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] last_grant;
    logic          found;
    logic [IW:0]   j;

    // first requester in order last_grant+1, last_grant+2, ... wrapping at N
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        j       = '0;
        for (int i = 1; i <= N; i++) begin
            j = {1'b0, last_grant} + (IW+1)'(i);
            j = (j >= (IW+1)'(N)) ? j - (IW+1)'(N) : j;
            if (!found && req[j[IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = j[IW-1:0];
            end
        end
        gnt = found ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end

    // pointer resets to N-1 so port 0 has first priority; moves only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= IW'(N-1);
        else if (advance)
            last_grant <= gnt_idx;
    end

endmodule

// File: rtl/depkt_rr_scheduler.sv
// depkt_rr_scheduler: round-robin share of one depacketizer among N packet sources
module depkt_rr_scheduler
    import fabricport_pkg::*;
#(
    parameter int WIDTH_PKT        = 36,
    parameter int N_PORTS          = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int CNT_WIDTH        = 16,
    localparam int PW = $clog2(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PORTS*WIDTH_PKT-1:0] i_packet_in,
    output logic [N_PORTS-1:0]           i_ready_out,
    input  logic                         i_pause,
    output logic [WIDTH_PKT-1:0]         o_packet_out,
    input  logic                         o_ready_in,
    output logic [PW-1:0]                o_grant_port,
    output logic [CNT_WIDTH-1:0]         o_pkt_count
);

    localparam int VP = valid_pos(WIDTH_PKT);

    if (VC_ADDRESS_WIDTH + ADDRESS_WIDTH >= flit_width(WIDTH_PKT)) begin : g_bad_widths
        $error("VC and address fields do not fit in a flit");
    end

    sched_state_t       state, state_nxt;
    logic [N_PORTS-1:0] req, gnt;
    logic [PW-1:0]      gnt_idx;
    logic               load_en, deliver;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_req
        assign req[p] = i_packet_in[p*WIDTH_PKT + VP];
    end

    assign deliver     = (state == FULL) && o_ready_in;
    assign load_en     = rst_n && ((state == EMPTY) || o_ready_in) && !i_pause && |req;
    assign i_ready_out = load_en ? gnt : '0;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (load_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // a load keeps or makes us FULL; a delivery without reload empties
    always_comb begin
        state_nxt = load_en ? FULL : deliver ? EMPTY : state;
    end

    // output register: take the winner verbatim, clear on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_packet_out <= '0;
            o_grant_port <= '0;
        end else if (load_en) begin
            o_packet_out <= i_packet_in[gnt_idx*WIDTH_PKT +: WIDTH_PKT];
            o_grant_port <= gnt_idx;
        end else if (deliver) begin
            o_packet_out <= '0;
        end
    end

    // delivered-packet counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_pkt_count <= '0;
        else if (deliver)
            o_pkt_count <= o_pkt_count + CNT_WIDTH'(1);
    end

endmodule
